ps2_mouse_ctrl: RTL and testbench

Sequences the PS/2 mouse link. Drives ps2_rx (receive enable) and ps2_tx (command writes) through the power-up handshake: reset command, ACK, self-test, ID, enable-reporting, ACK. Then assembles stream-mode bytes into 3-byte movement packets. Sits between the PS/2 PHY pair and the application logic that consumes mouse packets.

---
 rtl/ps2_mouse_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_ctrl
//
// Brings up a PS/2 mouse and then turns its stream-mode bytes into
// 3-byte movement packets. It sits between the ps2_rx/ps2_tx PHY pair and
// the application logic that consumes mouse packets.
//
// Power-up handshake:
//   send 0xFF (reset), expect 0xFA (ack), 0xAA (self-test pass), 0x00 (id),
//   send 0xF4 (enable reporting), expect 0xFA (ack), then stream.
// A timeout or an unexpected byte in any wait state restarts the handshake
// from 0xFF. After MAX_RETRY failed attempts the block parks in ERROR until
// reset.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous reset, active low
//   rx_en         receive enable to ps2_rx
//   rx_data       received byte from ps2_rx
//   rx_done_tick  1-cycle strobe, rx_data valid
//   tx_wr         1-cycle write strobe to ps2_tx
//   tx_data       command byte to ps2_tx (holds between writes)
//   tx_idle       ps2_tx ready to accept a byte
//   tx_done_tick  1-cycle strobe, transmission complete
//   init_done     high while streaming
//   err           sticky init failure
//   btn           {middle, right, left}
//   dx, dy        9-bit two's complement movement
//   x_ov, y_ov    movement overflow flags
//   pkt_valid     1-cycle strobe, packet outputs updated
//
// States:
//   state      | meaning
//   IDLE       | one cycle after reset, then start init
//   SEND_RST   | wait for tx_idle, write 0xFF
//   WAIT_TX1   | wait for 0xFF to finish transmitting
//   WAIT_ACK1  | expect 0xFA
//   WAIT_BAT   | expect 0xAA (long self-test timeout)
//   WAIT_ID    | expect 0x00
//   SEND_EN    | wait for tx_idle, write 0xF4
//   WAIT_TX2   | wait for 0xF4 to finish transmitting
//   WAIT_ACK2  | expect 0xFA
//   STREAM_B1  | wait for packet header (bit3 must be set)
//   STREAM_B2  | wait for X byte
//   STREAM_B3  | wait for Y byte, publish packet
//   ERROR      | init failed MAX_RETRY times, only reset exits
// ---------------------------------------------------------------------------
module ps2_mouse_ctrl #(
    parameter int TIMEOUT_CYC     = 2_500_000,
    parameter int BAT_TIMEOUT_CYC = 50_000_000,
    parameter int PKT_GAP_CYC     = 200_000,
    parameter int MAX_RETRY       = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       rx_en,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic       init_done,
    output logic       err,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ov,
    output logic       y_ov,
    output logic       pkt_valid
);

    localparam int TMR_MAX_A = (TIMEOUT_CYC > BAT_TIMEOUT_CYC) ? TIMEOUT_CYC : BAT_TIMEOUT_CYC;
    localparam int TMR_MAX   = (TMR_MAX_A > PKT_GAP_CYC) ? TMR_MAX_A : PKT_GAP_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int RTY_W     = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TMR_MAX);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT    = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [3:0] {
        IDLE,
        SEND_RST,
        WAIT_TX1,
        WAIT_ACK1,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_TX2,
        WAIT_ACK2,
        STREAM_B1,
        STREAM_B2,
        STREAM_B3,
        ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_lim;
    logic [TMR_W:0]   tmr_inc;
    logic             tmr_exp;
    logic [RTY_W-1:0] retry, retry_nxt;
    logic             fail;

    // Header byte minus bit3, which is only a sync marker.
    logic [6:0]       hdr, hdr_nxt;
    logic [7:0]       b2, b2_nxt;

    logic             rx_en_nxt;
    logic             tx_wr_nxt;
    logic [7:0]       tx_data_nxt;
    logic             init_done_nxt;
    logic             err_nxt;
    logic [2:0]       btn_nxt;
    logic [8:0]       dx_nxt;
    logic [8:0]       dy_nxt;
    logic             x_ov_nxt;
    logic             y_ov_nxt;
    logic             pkt_valid_nxt;

    // Per-state timeout limit. SEND_* and STREAM_B1 never time out, so their
    // limit is irrelevant.
    always_comb begin
        tmr_lim = TMR_W'(TIMEOUT_CYC);
        case (state)
            WAIT_BAT:             tmr_lim = TMR_W'(BAT_TIMEOUT_CYC);
            STREAM_B2, STREAM_B3: tmr_lim = TMR_W'(PKT_GAP_CYC);
            default:              tmr_lim = TMR_W'(TIMEOUT_CYC);
        endcase
    end

    // tmr is 0 on the first cycle of a state, so the limit is reached after
    // exactly tmr_lim cycles in that state.
    assign tmr_inc = {1'b0, tmr} + {{TMR_W{1'b0}}, 1'b1};
    assign tmr_exp = (tmr_inc >= {1'b0, tmr_lim});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tmr       <= '0;
            retry     <= '0;
            hdr       <= '0;
            b2        <= '0;
            rx_en     <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            x_ov      <= 1'b0;
            y_ov      <= 1'b0;
            pkt_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                tmr <= '0;
            end else if (tmr != TMR_SAT) begin
                tmr <= tmr + TMR_W'(1);
            end
            retry     <= retry_nxt;
            hdr       <= hdr_nxt;
            b2        <= b2_nxt;
            rx_en     <= rx_en_nxt;
            tx_wr     <= tx_wr_nxt;
            tx_data   <= tx_data_nxt;
            init_done <= init_done_nxt;
            err       <= err_nxt;
            btn       <= btn_nxt;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            x_ov      <= x_ov_nxt;
            y_ov      <= y_ov_nxt;
            pkt_valid <= pkt_valid_nxt;
        end
    end

    // A received byte always wins over a timeout expiring in the same cycle,
    // so every wait state checks rx_done_tick before tmr_exp.
    always_comb begin
        state_nxt     = state;
        retry_nxt     = retry;
        hdr_nxt       = hdr;
        b2_nxt        = b2;
        fail          = 1'b0;
        tx_wr_nxt     = 1'b0;
        tx_data_nxt   = tx_data;
        btn_nxt       = btn;
        dx_nxt        = dx;
        dy_nxt        = dy;
        x_ov_nxt      = x_ov;
        y_ov_nxt      = y_ov;
        pkt_valid_nxt = 1'b0;

        case (state)
            IDLE: state_nxt = SEND_RST;

            SEND_RST: begin
                if (tx_idle) begin
                    tx_wr_nxt   = 1'b1;
                    tx_data_nxt = CMD_RESET;
                    state_nxt   = WAIT_TX1;
                end
            end

            WAIT_TX1: begin
                if (tx_done_tick) state_nxt = WAIT_ACK1;
                else if (tmr_exp) fail = 1'b1;
            end

            WAIT_ACK1: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_ACK) state_nxt = WAIT_BAT;
                    else                    fail = 1'b1;
                end else if (tmr_exp) begin
                    fail = 1'b1;
                end
            end

            WAIT_BAT: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_BAT) state_nxt = WAIT_ID;
                    else                    fail = 1'b1;
                end else if (tmr_exp) begin
                    fail = 1'b1;
                end
            end

            WAIT_ID: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_ID) state_nxt = SEND_EN;
                    else                   fail = 1'b1;
                end else if (tmr_exp) begin
                    fail = 1'b1;
                end
            end

            SEND_EN: begin
                if (tx_idle) begin
                    tx_wr_nxt   = 1'b1;
                    tx_data_nxt = CMD_ENABLE;
                    state_nxt   = WAIT_TX2;
                end
            end

            WAIT_TX2: begin
                if (tx_done_tick) state_nxt = WAIT_ACK2;
                else if (tmr_exp) fail = 1'b1;
            end

            WAIT_ACK2: begin
                if (rx_done_tick) begin
                    if (rx_data == RSP_ACK) state_nxt = STREAM_B1;
                    else                    fail = 1'b1;
                end else if (tmr_exp) begin
                    fail = 1'b1;
                end
            end

            // Bytes without the bit3 marker cannot be a header; dropping them
            // lets the packet framing recover after a lost byte.
            STREAM_B1: begin
                if (rx_done_tick && rx_data[3]) begin
                    hdr_nxt   = {rx_data[7:4], rx_data[2:0]};
                    state_nxt = STREAM_B2;
                end
            end

            STREAM_B2: begin
                if (rx_done_tick) begin
                    b2_nxt    = rx_data;
                    state_nxt = STREAM_B3;
                end else if (tmr_exp) begin
                    state_nxt = STREAM_B1;
                end
            end

            STREAM_B3: begin
                if (rx_done_tick) begin
                    btn_nxt       = hdr[2:0];
                    dx_nxt        = {hdr[3], b2};
                    dy_nxt        = {hdr[4], rx_data};
                    x_ov_nxt      = hdr[5];
                    y_ov_nxt      = hdr[6];
                    pkt_valid_nxt = 1'b1;
                    state_nxt     = STREAM_B1;
                end else if (tmr_exp) begin
                    state_nxt = STREAM_B1;
                end
            end

            ERROR: state_nxt = ERROR;

            default: state_nxt = IDLE;
        endcase

        if (fail) begin
            if (retry == RTY_LAST) begin
                state_nxt = ERROR;
            end else begin
                retry_nxt = retry + RTY_W'(1);
                state_nxt = SEND_RST;
            end
        end

        rx_en_nxt     = state_nxt inside {WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2,
                                          STREAM_B1, STREAM_B2, STREAM_B3};
        init_done_nxt = state_nxt inside {STREAM_B1, STREAM_B2, STREAM_B3};
        err_nxt       = (state_nxt == ERROR);
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_mouse_ctrl. Plays the mouse side of the handshake by
// hand, keeps queues of expected command writes and expected packets, and a
// negedge monitor pops and compares them whenever the DUT emits tx_wr or
// pkt_valid. Any emission with nothing expected is reported.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_ctrl;

    localparam int TIMEOUT_CYC     = 100;
    localparam int BAT_TIMEOUT_CYC = 400;
    localparam int PKT_GAP_CYC     = 50;
    localparam int MAX_RETRY       = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       init_done;
    logic       err;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       x_ov;
    logic       y_ov;
    logic       pkt_valid;

    ps2_mouse_ctrl #(
        .TIMEOUT_CYC    (TIMEOUT_CYC),
        .BAT_TIMEOUT_CYC(BAT_TIMEOUT_CYC),
        .PKT_GAP_CYC    (PKT_GAP_CYC),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_en       (rx_en),
        .rx_data     (rx_data),
        .rx_done_tick(rx_done_tick),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .init_done   (init_done),
        .err         (err),
        .btn         (btn),
        .dx          (dx),
        .dy          (dy),
        .x_ov        (x_ov),
        .y_ov        (y_ov),
        .pkt_valid   (pkt_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       x_ov;
        logic       y_ov;
    } pkt_t;

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        pkt_t       exp;
    } pkt_vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_tx[$];
    pkt_t       exp_pkt[$];

    // Scoreboard monitor, sampling on the inactive edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_wr) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: tx_wr with tx_data=%02h, no write expected", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %02h expected %02h", tx_data, e);
                    end
                end
            end
            if (pkt_valid) begin
                checks++;
                if (exp_pkt.size() == 0) begin
                    errors++;
                    $display("FAIL pkt_unexpected: pkt_valid with btn=%b dx=%03h dy=%03h", btn, dx, dy);
                end else begin
                    pkt_t e;
                    pkt_t a;
                    e = exp_pkt.pop_front();
                    a = '{btn, dx, dy, x_ov, y_ov};
                    if (a !== e) begin
                        errors++;
                        $display("FAIL pkt: got btn=%b dx=%03h dy=%03h xov=%b yov=%b expected btn=%b dx=%03h dy=%03h xov=%b yov=%b",
                                 a.btn, a.dx, a.dy, a.x_ov, a.y_ov, e.btn, e.dx, e.dy, e.x_ov, e.y_ov);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected below 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
    endtask

    // Expects a write of b within budget cycles; returns the cycles waited.
    task automatic wait_tx(input logic [7:0] b, input int budget, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        exp_tx.push_back(b);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            waited = i + 1;
            if (tx_wr) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tx_timeout: no tx_wr of %02h within %0d cycles", b, budget);
            exp_tx.delete();
        end
    endtask

    task automatic outputs_zero(input string name);
        chk(name, {28'd0, rx_en, tx_wr, tx_data, init_done, err, btn, dx, dy, x_ov, y_ov, pkt_valid}, 64'd0);
    endtask

    // Everything after the 0xFF write has been seen.
    task automatic do_init_rest();
        int w;
        chk("rx_en_wait_tx1", {63'd0, rx_en}, 64'd0);
        pulse_tx_done();
        chk("rx_en_wait_ack1", {63'd0, rx_en}, 64'd1);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_tx(8'hF4, 10, w);
        pulse_tx_done();
        chk("init_done_before_ack2", {63'd0, init_done}, 64'd0);
        send_rx(8'hFA);
        chk("init_done_after_ack2", {63'd0, init_done}, 64'd1);
        chk("err_after_init", {63'd0, err}, 64'd0);
        chk("tx_data_hold", {56'd0, tx_data}, {56'd0, 8'hF4});
    endtask

    task automatic do_init();
        int w;
        wait_tx(8'hFF, 10, w);
        do_init_rest();
    endtask

    task automatic drain(input string name);
        cyc(2);
        chk(name, exp_pkt.size(), 64'd0);
    endtask

    pkt_vec_t vecs[5];

    initial begin
        int w;

        vecs[0] = '{8'h29, 8'h05, 8'hFE, '{3'b001, 9'h005, 9'h1FE, 1'b0, 1'b0}};
        vecs[1] = '{8'h08, 8'h00, 8'h00, '{3'b000, 9'h000, 9'h000, 1'b0, 1'b0}};
        vecs[2] = '{8'h1F, 8'h80, 8'h7F, '{3'b111, 9'h180, 9'h07F, 1'b0, 1'b0}};
        vecs[3] = '{8'hC8, 8'hFF, 8'hFF, '{3'b000, 9'h0FF, 9'h0FF, 1'b1, 1'b1}};
        vecs[4] = '{8'h3A, 8'h01, 8'h02, '{3'b010, 9'h101, 9'h102, 1'b0, 1'b0}};

        reset_n      = 1'b0;
        rx_data      = 8'h00;
        rx_done_tick = 1'b0;
        tx_idle      = 1'b0;
        tx_done_tick = 1'b0;
        cyc(3);
        outputs_zero("reset_outputs");

        // Normal init, with ps2_tx busy for a while first.
        reset_n = 1'b1;
        cyc(10);
        chk("rx_en_send_rst", {63'd0, rx_en}, 64'd0);
        tx_idle = 1'b1;
        do_init();

        // Packets from the table, including sign and overflow bits.
        foreach (vecs[i]) begin
            exp_pkt.push_back(vecs[i].exp);
            send_rx(vecs[i].b1);
            send_rx(vecs[i].b2);
            send_rx(vecs[i].b3);
            cyc(1);
        end
        drain("pkt_table_drain");

        // Resync: byte without bit3 is dropped.
        exp_pkt.push_back('{3'b000, 9'h000, 9'h000, 1'b0, 1'b0});
        send_rx(8'h01);
        send_rx(8'h08);
        send_rx(8'h00);
        send_rx(8'h00);
        drain("pkt_resync_drain");

        // Stray tx_done in STREAM changes nothing.
        pulse_tx_done();
        cyc(3);
        chk("init_done_after_stray_tx_done", {63'd0, init_done}, 64'd1);

        // Inter-byte gap drops the partial packet.
        exp_pkt.push_back('{3'b000, 9'h001, 9'h002, 1'b0, 1'b0});
        send_rx(8'h08);
        cyc(PKT_GAP_CYC + 2);
        send_rx(8'h08);
        send_rx(8'h01);
        send_rx(8'h02);
        drain("pkt_gap_drain");

        // Reset mid-packet.
        send_rx(8'h08);
        send_rx(8'h11);
        #2;
        reset_n = 1'b0;
        #1;
        outputs_zero("reset_mid_stream");
        cyc(2);
        reset_n = 1'b1;

        // Wrong ACK forces an immediate resend, then init completes.
        wait_tx(8'hFF, 10, w);
        pulse_tx_done();
        send_rx(8'hFE);
        wait_tx(8'hFF, 10, w);
        chk("resend_latency_ok", {63'd0, (w <= 3)}, 64'd1);
        do_init_rest();
        exp_pkt.push_back('{3'b001, 9'h003, 9'h004, 1'b0, 1'b0});
        send_rx(8'h09);
        send_rx(8'h03);
        send_rx(8'h04);
        drain("pkt_after_reset_drain");

        // Timeout/retry into ERROR.
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        for (int k = 0; k < MAX_RETRY; k++) begin
            wait_tx(8'hFF, (k == 0) ? 10 : 3 * TIMEOUT_CYC, w);
            if (k != 0) begin
                chk("retry_gap_ok", {63'd0, (w >= TIMEOUT_CYC - 5) && (w <= TIMEOUT_CYC + 10)}, 64'd1);
            end
            pulse_tx_done();
        end
        cyc(TIMEOUT_CYC + 50);
        chk("err_after_retries", {63'd0, err}, 64'd1);
        chk("rx_en_in_error", {63'd0, rx_en}, 64'd0);
        chk("init_done_in_error", {63'd0, init_done}, 64'd0);

        // ERROR ignores further traffic.
        send_rx(8'hFA);
        pulse_tx_done();
        cyc(2 * TIMEOUT_CYC);
        chk("err_sticky", {63'd0, err}, 64'd1);
        chk("tx_queue_empty", exp_tx.size(), 64'd0);
        chk("pkt_queue_empty", exp_pkt.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
